// File: rtl/mast_dp_pkg.sv
// Shared encodings and widths for the master-side I2C datapath.
package mast_dp_pkg;

  localparam int BYTE_W   = 8;
  localparam int BITCNT_W = 4;

  localparam logic [BITCNT_W-1:0] CNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    MUX_START = 2'b00,
    MUX_ADD   = 2'b01,
    MUX_DATA  = 2'b10,
    MUX_ACK   = 2'b11
  } mux_sel_e;

endpackage

// File: rtl/mast_piso8.sv
// 8-bit load/shift register with saturating bit counter and done pulse.
// Updates on the falling edge of the bit-period clock.
module mast_piso8
  import mast_dp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] load_val,
  output logic              msb,
  output logic              full,
  output logic              done
);

  logic [BYTE_W-1:0]   sr;
  logic [BITCNT_W-1:0] cnt;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        sr  <= load_val;
        cnt <= '0;
      end else if (shift && (cnt < CNT_FULL)) begin
        sr   <= {sr[BYTE_W-2:0], 1'b0};
        cnt  <= cnt + 1'b1;
        done <= (cnt == CNT_FULL - 1'b1);
      end
    end
  end

  assign msb  = sr[BYTE_W-1];
  assign full = (cnt == CNT_FULL);

endmodule

// File: rtl/mast_datapath.sv
// Master I2C datapath: address/data serialisers, receive SIPO, SDA mux and ACK sampler.
// Optional sticky overrun checker enabled by defining MAST_DP_BITCHK_EN.
module mast_datapath
  import mast_dp_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic              master_scl_sixt,
  input  logic              master_rst,
  input  logic [6:0]        master_addr,
  input  logic              master_rd_wr,
  input  logic [BYTE_W-1:0] master_tx_data,
  input  logic              master_load_add,
  input  logic              master_shift_add,
  input  logic              master_load_data,
  input  logic              master_shift_data,
  input  logic [1:0]        master_mux_sel,
  input  logic              master_tri_en,
  input  logic              master_demux_sel,
  input  logic              master_shift_d_slave,
  input  logic              master_ack_sel,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              sda_oe,
  output logic              master_ack,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_done,
  output logic              dp_err
);

  logic       add_msb, add_full, add_done;
  logic       data_msb, data_full, data_done;
  logic       rx_en;
  logic [BYTE_W-1:0] rx_sr;
  logic [2:0] rx_cnt;

  mast_piso8 u_add (
    .clk      (master_scl_sixt),
    .rst      (master_rst),
    .load     (master_load_add),
    .shift    (master_shift_add),
    .load_val ({master_addr, master_rd_wr}),
    .msb      (add_msb),
    .full     (add_full),
    .done     (add_done)
  );

  mast_piso8 u_data (
    .clk      (master_scl_sixt),
    .rst      (master_rst),
    .load     (master_load_data),
    .shift    (master_shift_data),
    .load_val (master_tx_data),
    .msb      (data_msb),
    .full     (data_full),
    .done     (data_done)
  );

  assign tx_done = add_done | data_done;
  assign sda_oe  = ~master_tri_en;
  assign rx_en   = master_demux_sel & master_shift_d_slave;

  always_comb begin
    sda_out = 1'b0;
    case (mux_sel_e'(master_mux_sel))
      MUX_START: sda_out = 1'b0;
      MUX_ADD:   sda_out = add_msb;
      MUX_DATA:  sda_out = data_msb;
      MUX_ACK:   sda_out = ~master_ack_sel;
      default:   sda_out = 1'b0;
    endcase
  end

  // Dropping either receive enable discards the partial byte.
  always_ff @(negedge master_scl_sixt or posedge master_rst) begin
    if (master_rst) begin
      rx_sr    <= '0;
      rx_cnt   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_en) begin
        rx_sr <= {rx_sr[BYTE_W-2:0], sda_in};
        if (rx_cnt == 3'd7) begin
          rx_data  <= {rx_sr[BYTE_W-2:0], sda_in};
          rx_valid <= 1'b1;
          rx_cnt   <= '0;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else begin
        rx_cnt <= '0;
      end
    end
  end

  always_ff @(negedge master_scl_sixt or posedge master_rst) begin
    if (master_rst)
      master_ack <= 1'b1;
    else if (master_tri_en && !master_shift_d_slave)
      master_ack <= sda_in;
  end

`ifdef MAST_DP_BITCHK_EN
  logic err_set;

  assign err_set = (master_shift_add  & add_full)
                 | (master_shift_data & data_full)
                 | (master_load_add   & master_shift_add)
                 | (master_load_data  & master_shift_data)
                 | (rx_en & (master_shift_add | master_shift_data));

  always_ff @(negedge master_scl_sixt or posedge master_rst) begin
    if (master_rst)
      dp_err <= 1'b0;
    else if (err_set)
      dp_err <= 1'b1;
  end
`else
  logic unused_full;
  assign unused_full = add_full ^ data_full;
  assign dp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mast_datapath.sv
// Directed vector bench for mast_datapath; inputs change on the rising edge,
// outputs are checked on the rising edge after each active falling edge.
module tb_mast_datapath;
  import mast_dp_pkg::*;

`ifdef MAST_DP_BITCHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] master_addr;
  logic       master_rd_wr;
  logic [7:0] master_tx_data;
  logic       master_load_add, master_shift_add, master_load_data, master_shift_data;
  logic [1:0] master_mux_sel;
  logic       master_tri_en, master_demux_sel, master_shift_d_slave, master_ack_sel;
  logic       sda_in;
  logic       sda_out, sda_oe, master_ack, rx_valid, tx_done, dp_err;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;

  mast_datapath #(.BYTE_W(8)) dut (
    .master_scl_sixt      (clk),
    .master_rst           (rst),
    .master_addr          (master_addr),
    .master_rd_wr         (master_rd_wr),
    .master_tx_data       (master_tx_data),
    .master_load_add      (master_load_add),
    .master_shift_add     (master_shift_add),
    .master_load_data     (master_load_data),
    .master_shift_data    (master_shift_data),
    .master_mux_sel       (master_mux_sel),
    .master_tri_en        (master_tri_en),
    .master_demux_sel     (master_demux_sel),
    .master_shift_d_slave (master_shift_d_slave),
    .master_ack_sel       (master_ack_sel),
    .sda_in               (sda_in),
    .sda_out              (sda_out),
    .sda_oe               (sda_oe),
    .master_ack           (master_ack),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .tx_done              (tx_done),
    .dp_err               (dp_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0] ls;     // {load_add, shift_add, load_data, shift_data}
    logic [1:0] mux;
    logic       tri_en, dmx, sds, acks, sin;
    logic       e_sda, e_ack, e_rxv, e_txd;
    logic [7:0] e_rx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [3:0] ls, logic [1:0] mux, logic tri_en, logic dmx,
                             logic sds, logic acks, logic sin, logic e_sda, logic e_ack,
                             logic [7:0] e_rx, logic e_rxv, logic e_txd);
    vec_t r;
    r.ls = ls; r.mux = mux; r.tri_en = tri_en; r.dmx = dmx; r.sds = sds;
    r.acks = acks; r.sin = sin; r.e_sda = e_sda; r.e_ack = e_ack;
    r.e_rx = e_rx; r.e_rxv = e_rxv; r.e_txd = e_txd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    {master_load_add, master_shift_add, master_load_data, master_shift_data} = x.ls;
    master_mux_sel       = x.mux;
    master_tri_en        = x.tri_en;
    master_demux_sel     = x.dmx;
    master_shift_d_slave = x.sds;
    master_ack_sel       = x.acks;
    sda_in               = x.sin;
  endtask

  task automatic edge_step();
    @(negedge clk);
    @(posedge clk);
  endtask

  initial begin
    logic [7:0]  a_bits, d_bits, rx_bits;
    logic [15:0] stream;
    vec_t        idle;

    rst = 1'b1;
    master_addr = 7'h50; master_rd_wr = 1'b0; master_tx_data = 8'hA5;
    idle = v(4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    drive(idle);
    @(posedge clk);
    chk("rst_sda_out",  {7'd0, sda_out},    8'd0);
    chk("rst_sda_oe",   {7'd0, sda_oe},     8'd1);
    chk("rst_ack",      {7'd0, master_ack}, 8'd1);
    chk("rst_rx_data",  rx_data,            8'h00);
    chk("rst_rx_valid", {7'd0, rx_valid},   8'd0);
    chk("rst_tx_done",  {7'd0, tx_done},    8'd0);
    chk("rst_dp_err",   {7'd0, dp_err},     8'd0);
    rst = 1'b0;

    // Address frame 0xA0, then data frame 0xA5 with one extra shift
    a_bits = 8'hA0;
    d_bits = 8'hA5;
    vecs.push_back(v(4'b1000, 2'b01, 0, 0, 0, 0, 0, a_bits[7], 1, 8'h00, 0, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(v(4'b0100, 2'b01, 0, 0, 0, 0, 0, (i < 8) ? a_bits[7-i] : 1'b0,
                       1, 8'h00, 0, i == 8));
    vecs.push_back(v(4'b0000, 2'b01, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0));
    vecs.push_back(v(4'b0010, 2'b10, 0, 0, 0, 0, 0, d_bits[7], 1, 8'h00, 0, 0));
    for (int i = 1; i <= 9; i++)
      vecs.push_back(v(4'b0001, 2'b10, 0, 0, 0, 0, 0, (i < 8) ? d_bits[7-i] : 1'b0,
                       1, 8'h00, 0, i == 8));
    // Receive 0x3C
    rx_bits = 8'h3C;
    for (int i = 0; i < 8; i++)
      vecs.push_back(v(4'b0000, 2'b11, 1, 1, 1, 0, rx_bits[7-i], 1, 1,
                       (i == 7) ? 8'h3C : 8'h00, i == 7, 0));
    // Partial byte: 5 bits, enables drop (ack slot samples 0), 3 more bits
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(4'b0000, 2'b11, 1, 1, 1, 0, 1, 1, 1, 8'h3C, 0, 0));
    vecs.push_back(v(4'b0000, 2'b11, 1, 0, 0, 0, 0, 1, 0, 8'h3C, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(4'b0000, 2'b11, 1, 1, 1, 0, 1, 1, 0, 8'h3C, 0, 0));
    vecs.push_back(v(4'b0000, 2'b11, 1, 0, 0, 0, 1, 1, 1, 8'h3C, 0, 0));
    vecs.push_back(v(4'b0000, 2'b11, 0, 0, 0, 1, 0, 0, 1, 8'h3C, 0, 0));

    @(posedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i]);
      edge_step();
      chk($sformatf("v%0d_sda_out", i),  {7'd0, sda_out},    {7'd0, vecs[i].e_sda});
      chk($sformatf("v%0d_sda_oe", i),   {7'd0, sda_oe},     {7'd0, ~vecs[i].tri_en});
      chk($sformatf("v%0d_ack", i),      {7'd0, master_ack}, {7'd0, vecs[i].e_ack});
      chk($sformatf("v%0d_rx_data", i),  rx_data,            vecs[i].e_rx);
      chk($sformatf("v%0d_rx_valid", i), {7'd0, rx_valid},   {7'd0, vecs[i].e_rxv});
      chk($sformatf("v%0d_tx_done", i),  {7'd0, tx_done},    {7'd0, vecs[i].e_txd});
    end

    // Back-to-back receive 0x5A, 0xC3 with no gap
    stream = 16'h5AC3;
    for (int i = 0; i < 16; i++) begin
      drive(v(4'b0000, 2'b11, 1, 1, 1, 0, stream[15-i], 0, 0, 8'h00, 0, 0));
      edge_step();
      chk($sformatf("b2b%0d_rx_valid", i), {7'd0, rx_valid}, {7'd0, (i == 7) || (i == 15)});
      if (i == 7)  chk("b2b_rx_data0", rx_data, 8'h5A);
      if (i == 15) chk("b2b_rx_data1", rx_data, 8'hC3);
    end

    // Reset after 3 address shifts of 0xFF, with ack sampled low beforehand
    master_addr = 7'h7F; master_rd_wr = 1'b1;
    drive(v(4'b1000, 2'b01, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    edge_step();
    for (int i = 0; i < 3; i++) begin
      drive(v(4'b0100, 2'b01, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
      edge_step();
    end
    chk("pre_rst_sda_out", {7'd0, sda_out},    8'd1);
    chk("pre_rst_ack",     {7'd0, master_ack}, 8'd0);
    rst = 1'b1;
    #1;
    chk("arst_sda_out",  {7'd0, sda_out},    8'd0);
    chk("arst_ack",      {7'd0, master_ack}, 8'd1);
    chk("arst_rx_data",  rx_data,            8'h00);
    chk("arst_rx_valid", {7'd0, rx_valid},   8'd0);
    chk("arst_tx_done",  {7'd0, tx_done},    8'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(v(4'b0100, 2'b01, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
      edge_step();
      chk($sformatf("post_rst_shift%0d_sda", i), {7'd0, sda_out}, 8'd0);
    end
    drive(v(4'b1000, 2'b01, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    edge_step();
    chk("reload_sda", {7'd0, sda_out}, 8'd1);

    // Load and shift together: sticky error only when the checker is built in
    drive(v(4'b1100, 2'b01, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    edge_step();
    chk("dp_err_set", {7'd0, dp_err}, {7'd0, CHK});
    drive(idle);
    edge_step();
    edge_step();
    chk("dp_err_hold", {7'd0, dp_err}, {7'd0, CHK});
    rst = 1'b1;
    #1;
    chk("dp_err_rst", {7'd0, dp_err}, 8'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mast_datapath.md
# mast_datapath

Master-side I2C datapath sitting directly downstream of the master control FSM. It consumes the FSM's load, shift, mux, tri-state and demux controls and does the following:
- holds and serialises the 7-bit address plus R/W bit and the transmit byte onto SDA;
- deserialises received bytes from SDA;
- samples the slave ACK bit and returns it to the FSM as `master_ack`.

All state advances on the same bit-period clock as the FSM.

## Interface
Parameters:
- `BYTE_W`, 8, serial word width. Only 8 is supported; it is exposed for package consistency.

Ports:
- `master_scl_sixt` in 1: bit-period clock. All flops update on its falling edge, the same edge as the FSM.
- `master_rst` in 1: asynchronous, active-high reset.
- `master_addr` in 7: slave address, captured on load.
- `master_rd_wr` in 1: R/W bit, appended as the LSB of the address frame.
- `master_tx_data` in 8: write byte, captured on load.
- `master_load_add`, `master_shift_add`, `master_load_data`, `master_shift_data` in 1 each: FSM controls.
- `master_mux_sel` in 2: SDA source select.
- `master_tri_en` in 1: 1 = master releases SDA.
- `master_demux_sel`, `master_shift_d_slave` in 1 each: receive-path enables.
- `master_ack_sel` in 1: 1 = master drives ACK (low) in the ack slot.
- `sda_in` in 1: sampled bus level.
- `sda_out` out 1: driven SDA level (combinational).
- `sda_oe` out 1: output enable, equal to `~master_tri_en` (combinational).
- `master_ack` out 1: registered ACK sample back to the FSM. 0 = ACK.
- `rx_data` out 8: last fully received byte.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_done` out 1: one-cycle pulse on the 8th address or data shift.
- `dp_err` out 1: sticky overrun flag. Present only with `MAST_DP_BITCHK_EN`; otherwise tied to 0.

## Operation
- **Address register** (8 bits):
  - `master_load_add` = 1: load `{master_addr, master_rd_wr}` and clear its bit counter.
  - Otherwise, if `master_shift_add` = 1 and count < 8: shift left, fill with 0, and increment the count.
- **Data register**: same behaviour, using `master_load_data`, `master_shift_data` and `master_tx_data`.
- **Load vs shift**: load has priority over shift on the same edge.
- **`tx_done`**: pulses on the edge where either counter steps from 7 to 8.
- **SDA mux** (`sda_out`):
  - `00` → 0 (start / hold low).
  - `01` → address register bit 7.
  - `10` → data register bit 7.
  - `11` → 0 if `master_ack_sel` = 1, else 1 (NACK / stop release).
- **Receive path**, active when `master_demux_sel` and `master_shift_d_slave` are both 1:
  - Each edge: `rx_sr <= {rx_sr[6:0], sda_in}` and the receive count increments.
  - On the 8th bit: `rx_data <= {rx_sr[6:0], sda_in}`, `rx_valid` pulses and the receive count clears.
  - If either enable drops, the receive count clears and partial bits are discarded.
- **ACK sample**: `master_ack <= sda_in` on every edge with `master_tri_en` = 1 and `master_shift_d_slave` = 0. Otherwise `master_ack` holds.
- **Reset values**: all registers and counters 0; `master_ack` = 1 (NACK); `rx_data` = 0; `rx_valid`, `tx_done`, `dp_err` = 0.
- **Reset mid-transfer**: all state clears immediately (asynchronous). The next transfer requires a fresh load.

## Timing
- **Loads**: take effect on the falling edge where the control is high. The new MSB appears on `sda_out` in the same low phase, with zero added latency.
- **Shifts**: bit k (MSB first) is on `sda_out` between falling edges k and k+1 of the shift window.
- **Shift count limit**: 8 shift-enabled edges present all 8 bits. Further shift edges hold the count at 8 and present 0.
- **Receive latency**: `rx_valid` is asserted in the cycle after the 8th sampling edge, for exactly one cycle. Back-to-back bytes are supported with no gap cycle.
- **`master_ack`**: valid one edge after the ack-slot edge. The FSM reads it on the following edge.

## Configuration
- **`MAST_DP_BITCHK_EN` defined**: `dp_err` sets, and stays set until reset, when any of the following occurs:
  - a shift is requested at count 8;
  - load and shift are asserted on the same edge;
  - receive and transmit shift enables are asserted together.
- **`MAST_DP_BITCHK_EN` undefined**: the checker logic is absent and `dp_err` is constant 0. Behaviour is otherwise identical.

## Structure
- **Package `mast_dp_pkg`**:
  - mux encodings `MUX_START` = 2'b00, `MUX_ADD` = 2'b01, `MUX_DATA` = 2'b10, `MUX_ACK` = 2'b11;
  - `BYTE_W` = 8;
  - `BITCNT_W` = 4.
- **Sub-module `mast_piso8`**: 8-bit load/shift register with a saturating bit counter and done pulse. It is instantiated twice, once for address and once for data. The receive SIPO, mux and ACK sampler stay inline.

## Test plan
- **Address frame**: addr = 7'h50, rd_wr = 0, load_add then 8 shift_add edges with mux 01 → `sda_out` sequence 1,0,1,0,0,0,0,0; `tx_done` pulses once.
- **Data frame**: tx_data = 8'hA5, load_data then 8 shift_data edges with mux 10 → 1,0,1,0,0,1,0,1; a 9th shift edge → `sda_out` = 0, no second `tx_done`.
- **Receive**: `sda_in` sequence 0,0,1,1,1,1,0,0 with demux and shift_d_slave high → `rx_data` = 8'h3C, `rx_valid` one cycle. Enables dropped after 5 bits → no `rx_valid`.
- **ACK sampling**: tri_en = 1, `sda_in` = 0 → `master_ack` = 0 next edge. `sda_in` = 1 → `master_ack` = 1. Mux 11 with ack_sel = 1 → `sda_out` = 0, `sda_oe` = 1 when tri_en = 0.
- **Reset**: `master_rst` pulsed mid-shift (after bit 3) → all outputs reach reset values asynchronously; after release, the address register reads 0 until reloaded.
- **`MAST_DP_BITCHK_EN`**: load_add and shift_add asserted together → `dp_err` = 1 and stays 1 until reset. Without the macro, `dp_err` stays 0.
